// File: rtl/rv32_pkg.sv
// Shared RV32 register-file constants and types used by the writeback path.
package rv32_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // True when the destination is the hardwired-zero register.
    function automatic logic is_zero_reg(input reg_addr_t addr);
        return (addr == REG_ZERO);
    endfunction

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Bundle of the writeback arbiter's handshakes, register-file write port and scoreboard.
// "master" is the pipeline side that offers results; "slave" is the arbiter.
interface wb_write_arbiter_if #(
    parameter int XLEN = rv32_pkg::XLEN,
    parameter int AW   = rv32_pkg::REG_ADDR_W
);
    logic                 alu_valid;
    logic                 alu_ready;
    logic [AW-1:0]        alu_rd;
    logic [XLEN-1:0]      alu_data;

    logic                 ld_issue_valid;
    logic                 ld_issue_ready;
    logic [AW-1:0]        ld_issue_rd;

    logic                 ld_resp_valid;
    logic                 ld_resp_ready;
    logic [XLEN-1:0]      ld_resp_data;

    logic                 we3;
    logic [AW-1:0]        a3;
    logic [XLEN-1:0]      wd3;

    logic [(1<<AW)-1:0]   busy;
    logic                 lq_full;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_issue_valid, ld_issue_rd,
        output ld_resp_valid, ld_resp_data,
        input  alu_ready, ld_issue_ready, ld_resp_ready,
        input  we3, a3, wd3, busy, lq_full
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_issue_valid, ld_issue_rd,
        input  ld_resp_valid, ld_resp_data,
        output alu_ready, ld_issue_ready, ld_resp_ready,
        output we3, a3, wd3, busy, lq_full
    );
endinterface

// File: rtl/wb_tag_fifo.sv
// In-order tag FIFO holding destination registers of outstanding loads.
// Exposes per-entry valid bits and the raw tag storage so the owner can
// build a scoreboard without walking the pointers.
module wb_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [W-1:0]          din,
    input  logic                  pop,
    output logic [W-1:0]          dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH-1:0]      entry_valid,
    output logic [DEPTH-1:0][W-1:0] entries
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0]           wr_ptr_r;
    logic [PW-1:0]           rd_ptr_r;
    logic [DEPTH-1:0][W-1:0] mem_r;
    logic [DEPTH-1:0]        vld_r;
    logic                    full_s;
    logic                    empty_s;
    logic                    push_ok_s;
    logic                    pop_ok_s;

    // Wrap-bit pointer compare: equal means empty, MSB-only difference means full.
    always_comb begin
        empty_s   = (wr_ptr_r == rd_ptr_r);
        full_s    = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) &&
                    (wr_ptr_r[IW-1:0] == rd_ptr_r[IW-1:0]);
        push_ok_s = push & ~full_s;
        pop_ok_s  = pop & ~empty_s;
    end

    // Pointer advance on accepted push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Tag storage and occupancy bits; push and pop never hit the same slot
    // in one cycle because a pop needs non-empty and a push needs non-full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r <= '0;
            vld_r <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r[IW-1:0]] <= din;
                vld_r[wr_ptr_r[IW-1:0]] <= 1'b1;
            end
            if (pop_ok_s) begin
                vld_r[rd_ptr_r[IW-1:0]] <= 1'b0;
            end
        end
    end

    assign dout        = mem_r[rd_ptr_r[IW-1:0]];
    assign full        = full_s;
    assign empty       = empty_s;
    assign entry_valid = vld_r;
    assign entries     = mem_r;

endmodule

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges load responses and ALU results onto the single
// register-file write port, and exports a busy scoreboard of pending loads.
module wb_write_arbiter
    import rv32_pkg::*;
#(
    parameter int XLEN     = rv32_pkg::XLEN,
    parameter int AW       = rv32_pkg::REG_ADDR_W,
    parameter int LQ_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_write_arbiter_if.slave bus
);

    localparam int NR = 1 << AW;

    logic                          fifo_full_s;
    logic                          fifo_empty_s;
    logic [AW-1:0]                 head_rd_s;
    logic [LQ_DEPTH-1:0]           entry_valid_s;
    logic [LQ_DEPTH-1:0][AW-1:0]   entries_s;

    logic                          resp_fire_s;
    logic                          alu_ready_s;
    logic                          alu_fire_s;
    logic                          issue_ready_s;
    logic                          issue_fire_s;
    logic [NR-1:0]                 busy_s;

    logic                          we3_r;
    logic [AW-1:0]                 a3_r;
    logic [XLEN-1:0]               wd3_r;

    wb_tag_fifo #(
        .DEPTH (LQ_DEPTH),
        .W     (AW)
    ) u_tag_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (issue_fire_s),
        .din         (bus.ld_issue_rd),
        .pop         (resp_fire_s),
        .dout        (head_rd_s),
        .full        (fifo_full_s),
        .empty       (fifo_empty_s),
        .entry_valid (entry_valid_s),
        .entries     (entries_s)
    );

    // Scoreboard: OR of every valid queued tag; x0 can never be busy.
    always_comb begin
        busy_s = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            busy_s[entries_s[i]] = busy_s[entries_s[i]] | entry_valid_s[i];
        end
        busy_s[0] = 1'b0;
    end

    // Handshakes: a load response wins the port; ALU also waits on a pending load to its rd.
    always_comb begin
        issue_ready_s = ~fifo_full_s;
        issue_fire_s  = bus.ld_issue_valid & issue_ready_s;
        resp_fire_s   = bus.ld_resp_valid & ~fifo_empty_s;
        alu_ready_s   = ~resp_fire_s & ~busy_s[bus.alu_rd];
        alu_fire_s    = bus.alu_valid & alu_ready_s;
    end

    // Registered write port; address/data hold when idle, x0 writes are suppressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3_r <= 1'b0;
            a3_r  <= '0;
            wd3_r <= '0;
        end else if (resp_fire_s) begin
            we3_r <= ~is_zero_reg(head_rd_s);
            a3_r  <= head_rd_s;
            wd3_r <= bus.ld_resp_data;
        end else if (alu_fire_s) begin
            we3_r <= ~is_zero_reg(bus.alu_rd);
            a3_r  <= bus.alu_rd;
            wd3_r <= bus.alu_data;
        end else begin
            we3_r <= 1'b0;
        end
    end

    assign bus.alu_ready      = alu_ready_s;
    assign bus.ld_issue_ready = issue_ready_s;
    assign bus.ld_resp_ready  = ~fifo_empty_s;
    assign bus.we3            = we3_r;
    assign bus.a3             = a3_r;
    assign bus.wd3            = wd3_r;
    assign bus.busy           = busy_s;
    assign bus.lq_full        = fifo_full_s;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: ALU path, loads, conflicts, full queue,
// duplicate tags, x0 and mid-flight reset.
module tb_wb_write_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    wb_write_arbiter_if bus ();

    wb_write_arbiter #(
        .LQ_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.alu_valid      = 1'b0;
        bus.alu_rd         = 5'd0;
        bus.alu_data       = 32'h0;
        bus.ld_issue_valid = 1'b0;
        bus.ld_issue_rd    = 5'd0;
        bus.ld_resp_valid  = 1'b0;
        bus.ld_resp_data   = 32'h0;
    endtask

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        n_checks = 0;
        n_errors = 0;
        idle();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we3",        bus.we3, 1'b0);
        chk("rst_a3",         bus.a3, 5'd0);
        chk("rst_wd3",        bus.wd3, 32'h0);
        chk("rst_busy",       bus.busy, 32'h0);
        chk("rst_lq_full",    bus.lq_full, 1'b0);
        chk("rst_issue_rdy",  bus.ld_issue_ready, 1'b1);
        chk("rst_resp_rdy",   bus.ld_resp_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1. ALU only
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        settle();
        chk("t1_alu_ready", bus.alu_ready, 1'b1);
        tick();
        bus.alu_valid = 1'b0;
        chk("t1_we3", bus.we3, 1'b1);
        chk("t1_a3",  bus.a3, 5'd5);
        chk("t1_wd3", bus.wd3, 32'hDEADBEEF);
        tick();
        chk("t1_we3_drop", bus.we3, 1'b0);
        chk("t1_a3_hold",  bus.a3, 5'd5);

        // 2. Load to rd=7 blocks ALU WAW until committed
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd7;
        settle();
        chk("t2_issue_rdy", bus.ld_issue_ready, 1'b1);
        tick();
        bus.ld_issue_valid = 1'b0;
        chk("t2_busy_set", bus.busy, 32'h0000_0080);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h55;
        settle();
        chk("t2_alu_blocked", bus.alu_ready, 1'b0);
        tick();
        chk("t2_no_write", bus.we3, 1'b0);
        bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 32'h1234;
        settle();
        chk("t2_resp_rdy", bus.ld_resp_ready, 1'b1);
        chk("t2_alu_lose", bus.alu_ready, 1'b0);
        tick();
        bus.ld_resp_valid = 1'b0;
        chk("t2_ld_we3",  bus.we3, 1'b1);
        chk("t2_ld_a3",   bus.a3, 5'd7);
        chk("t2_ld_wd3",  bus.wd3, 32'h1234);
        chk("t2_busy_clr", bus.busy, 32'h0);
        settle();
        chk("t2_alu_unblk", bus.alu_ready, 1'b1);
        tick();
        bus.alu_valid = 1'b0;
        chk("t2_alu_we3", bus.we3, 1'b1);
        chk("t2_alu_a3",  bus.a3, 5'd7);
        chk("t2_alu_wd3", bus.wd3, 32'h55);

        // 3. Response and ALU in the same cycle
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd3;
        tick();
        bus.ld_issue_valid = 1'b0;
        chk("t3_busy", bus.busy, 32'h0000_0008);
        bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 32'hAA;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'hBB;
        settle();
        chk("t3_alu_rdy0", bus.alu_ready, 1'b0);
        tick();
        bus.ld_resp_valid = 1'b0;
        chk("t3_ld_we3", bus.we3, 1'b1);
        chk("t3_ld_a3",  bus.a3, 5'd3);
        chk("t3_ld_wd3", bus.wd3, 32'hAA);
        settle();
        chk("t3_alu_rdy1", bus.alu_ready, 1'b1);
        tick();
        bus.alu_valid = 1'b0;
        chk("t3_alu_a3",  bus.a3, 5'd4);
        chk("t3_alu_wd3", bus.wd3, 32'hBB);

        // 4. Fill the queue, refuse a 5th issue, drain in order
        for (int i = 1; i <= 4; i++) begin
            bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'(i);
            settle();
            chk("t4_issue_rdy", bus.ld_issue_ready, 1'b1);
            tick();
        end
        bus.ld_issue_rd = 5'd10;
        chk("t4_full",      bus.lq_full, 1'b1);
        chk("t4_busy_full", bus.busy, 32'h0000_001E);
        settle();
        chk("t4_issue_refused", bus.ld_issue_ready, 1'b0);
        tick();
        bus.ld_issue_valid = 1'b0;
        chk("t4_busy_no10", bus.busy, 32'h0000_001E);
        for (int i = 1; i <= 4; i++) begin
            bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 32'h100 + 32'(i);
            settle();
            chk("t4_resp_rdy", bus.ld_resp_ready, 1'b1);
            tick();
            chk("t4_order_a3",  bus.a3, 64'(i));
            chk("t4_order_wd3", bus.wd3, 64'(32'h100 + 32'(i)));
        end
        bus.ld_resp_valid = 1'b0;
        chk("t4_not_full", bus.lq_full, 1'b0);
        chk("t4_busy_empty", bus.busy, 32'h0);
        settle();
        chk("t4_resp_rdy_empty", bus.ld_resp_ready, 1'b0);
        tick();

        // 5. Duplicate rd=9, simultaneous issue+pop, then x0
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd9;
        tick();
        tick();
        bus.ld_issue_valid = 1'b0;
        chk("t5_busy_two", bus.busy, 32'h0000_0200);
        bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 32'h9A;
        tick();
        bus.ld_resp_valid = 1'b0;
        chk("t5_a3_first",   bus.a3, 5'd9);
        chk("t5_busy_still", bus.busy, 32'h0000_0200);
        bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 32'h9B;
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd9;
        settle();
        chk("t5_both_issue_rdy", bus.ld_issue_ready, 1'b1);
        chk("t5_both_resp_rdy",  bus.ld_resp_ready, 1'b1);
        tick();
        bus.ld_resp_valid = 1'b0; bus.ld_issue_valid = 1'b0;
        chk("t5_wd3_second", bus.wd3, 32'h9B);
        chk("t5_busy_kept",  bus.busy, 32'h0000_0200);
        bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 32'h9C;
        tick();
        bus.ld_resp_valid = 1'b0;
        chk("t5_wd3_third", bus.wd3, 32'h9C);
        chk("t5_busy_clr",  bus.busy, 32'h0);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h77;
        settle();
        chk("t5_x0_rdy", bus.alu_ready, 1'b1);
        tick();
        bus.alu_valid = 1'b0;
        chk("t5_x0_we3", bus.we3, 1'b0);

        // 6. Reset with two loads pending and a write on the port
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd12;
        tick();
        bus.ld_issue_rd = 5'd13;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_data = 32'h66;
        tick();
        bus.ld_issue_valid = 1'b0; bus.alu_valid = 1'b0;
        chk("t6_busy_pre", bus.busy, 32'h0000_3000);
        chk("t6_we3_pre",  bus.we3, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_busy_rst",  bus.busy, 32'h0);
        chk("t6_we3_rst",   bus.we3, 1'b0);
        chk("t6_a3_rst",    bus.a3, 5'd0);
        chk("t6_wd3_rst",   bus.wd3, 32'h0);
        chk("t6_full_rst",  bus.lq_full, 1'b0);
        chk("t6_resp_rdy_rst", bus.ld_resp_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 32'hBAD;
        settle();
        chk("t6_late_resp_rdy", bus.ld_resp_ready, 1'b0);
        chk("t6_alu_rdy",       bus.alu_ready, 1'b1);
        tick();
        bus.ld_resp_valid = 1'b0;
        chk("t6_late_we3",  bus.we3, 1'b0);
        chk("t6_late_busy", bus.busy, 32'h0);
        chk("t6_late_full", bus.lq_full, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
